imem_program_loader: RTL

// - Write-side master for the instruction memory load port. Takes a byte stream (UART/debug bridge),

---
 rtl/imem_program_loader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/imem_program_loader.sv
// Byte-stream loader for the instruction memory write port: little-endian word-count header,
// then N words, each written once; the core stays in reset until the load completes.
// Optional trailing XOR checksum byte is enabled with `define LOADER_CHECKSUM_EN.
module imem_program_loader #(
   parameter logic [63:0] BASE_ADDR = 64'h0,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        we,
   output logic [63:0] addr_w,
   output logic [31:0] data_w,
   output logic        core_rst_n,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR   = 3'd1,
      DATA  = 3'd2,
      WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
      CSUM  = 3'd4,
`endif
      DONE  = 3'd5,
      ERR   = 3'd6
   } state_t;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t LAST = CSUM;
`else
   localparam state_t LAST = DONE;
`endif

   state_t      state, nxt;
   logic [1:0]  bcnt;
   logic [31:0] nwords;
   logic [23:0] wbuf;
   logic [31:0] idx;
   logic        acc, last_byte;
   logic [31:0] n_full, w_full;
   logic        rdy_n, busy_n;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   assign acc       = s_valid & s_ready;
   assign last_byte = acc & (bcnt == 2'd3);
   // Bytes shift in from the top so the first byte lands in bits [7:0].
   assign n_full    = {s_data, nwords[31:8]};
   assign w_full    = {s_data, wbuf};

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE, DONE, ERR: if (start) nxt = HDR;
         HDR: begin
            if (last_byte) begin
               if (n_full > MAX_WORDS)   nxt = ERR;
               else if (n_full == 32'd0) nxt = LAST;
               else                      nxt = DATA;
            end
         end
         DATA:  if (last_byte) nxt = WRITE;
         WRITE: nxt = (idx == nwords) ? LAST : DATA;
`ifdef LOADER_CHECKSUM_EN
         CSUM:  if (acc) nxt = (s_data == csum) ? DONE : ERR;
`endif
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      rdy_n = (nxt == HDR) || (nxt == DATA);
`ifdef LOADER_CHECKSUM_EN
      rdy_n = rdy_n || (nxt == CSUM);
`endif
      busy_n = rdy_n || (nxt == WRITE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt   <= 2'd0;
         nwords <= 32'd0;
         wbuf   <= 24'd0;
         idx    <= 32'd0;
         addr_w <= BASE_ADDR;
         data_w <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
         csum   <= 8'd0;
`endif
      end else begin
         if (nxt == HDR && state != HDR) begin
            bcnt   <= 2'd0;
            nwords <= 32'd0;
            idx    <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            csum   <= 8'd0;
`endif
         end else if (acc && (state == HDR || state == DATA)) begin
            bcnt <= bcnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ s_data;
`endif
            if (state == HDR) nwords <= n_full;
            else              wbuf   <= w_full[31:8];
         end
         // Address/data are latched on the last byte so they are stable during the we cycle.
         if (state == DATA && last_byte) begin
            addr_w <= BASE_ADDR + {30'd0, idx, 2'b00};
            data_w <= w_full;
            idx    <= idx + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ready    <= 1'b0;
         we         <= 1'b0;
         core_rst_n <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         s_ready    <= rdy_n;
         we         <= (nxt == WRITE);
         core_rst_n <= (nxt == DONE);
         busy       <= busy_n;
         done       <= (nxt == DONE);
         error      <= (nxt == ERR);
      end
   end

endmodule
